dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the single byte-addressed, word-wide data memory (`datamem`) between two masters.
- Typical masters: a processor-side load/store unit and a debug/DMA master, e.g. a memory loader or result dumper.
- Sits between the masters and the `datamem` ports `data_addr`/`data_wr`/`data_in`/`data_out`.
- Sequences every access through a 3-state FSM with a req/ack handshake and an optional lock for back-to-back bursts.

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter for the shared data memory, with bounded lock bursts.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_wr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] MAX_H = 4'(MAX_HOLD);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, lock_q, lock_d, regrant, access;
  logic [3:0] hold_q, hold_d;
  logic [1:0] ack_q, ack_d, req, wr, lock;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  assign req      = {m1_req, m0_req};
  assign wr       = {m1_wr, m0_wr};
  assign lock     = {m1_lock, m0_lock};
  assign access   = state_q == ACCESS;
  assign data_wr   = access & wr[owner_q];
  assign data_addr = access ? (owner_q ? m1_addr : m0_addr) : '0;
  assign data_in   = access ? (owner_q ? m1_wdata : m0_wdata) : '0;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  // hold_q counts locked re-grants taken since the run's first grant
  assign regrant = lock_q && req[last_q] && hold_q < MAX_H;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    lock_d   = lock_q;
    hold_d   = hold_q;
    ack_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ACCESS;
        owner_d = regrant ? last_q : (&req ? ~last_q : req[1]);
        hold_d  = regrant ? hold_q + 4'd1 : 4'd0;
      end
      ACCESS: begin
        state_d  = RESP;
        ack_d    = owner_q ? 2'b10 : 2'b01;
        last_d   = owner_q;
        rdata0_d = (!owner_q && !m0_wr) ? data_out : rdata0_q;
        rdata1_d = (owner_q && !m1_wr) ? data_out : rdata1_q;
      end
      RESP: begin
        state_d = IDLE;
        lock_d  = lock[owner_q];
        hold_d  = (lock[owner_q] && req[!owner_q]) ? hold_q : 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      lock_q   <= 1'b0;
      hold_q   <= 4'd0;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      lock_q   <= lock_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a transaction-level grant/streak model and a byte-wide memory.
module tb_dmem_arbiter;
  localparam int MH = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = 2'b00, wr = 2'b00, lk = 2'b00;
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic ack0, ack1, d_wr;
  logic [31:0] rd0, rd1, d_addr, d_in, d_out;
  logic [7:0] mem [256];
  logic [7:0] ma;
  int cyc = 0, npass = 0, ntot = 0;
  int glog [$];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_wr(wr[0]), .m0_lock(lk[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
    .m0_ack(ack0), .m0_rdata(rd0),
    .m1_req(req[1]), .m1_wr(wr[1]), .m1_lock(lk[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
    .m1_ack(ack1), .m1_rdata(rd1),
    .data_addr(d_addr), .data_wr(d_wr), .data_in(d_in), .data_out(d_out)
  );

  always #5 clk = ~clk;

  // big-endian byte memory: the byte at the word address is the MSB
  assign ma = d_addr[7:0];
  assign d_out = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  function automatic logic [31:0] rdw(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h38] <= 8'h11; mem[8'h39] <= 8'h22; mem[8'h3A] <= 8'h33; mem[8'h3B] <= 8'h44;
    end else if (d_wr) begin
      mem[ma] <= d_in[31:24]; mem[ma + 8'd1] <= d_in[23:16];
      mem[ma + 8'd2] <= d_in[15:8]; mem[ma + 8'd3] <= d_in[7:0];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 memory access, 2 response. run = grants in the current locked streak.
  int mph, run;
  logic mown, mlast, mlock, m_regr;
  logic [31:0] mrd [2];
  assign m_regr = mlock && req[mlast] && run <= MH;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph <= 0; mown <= 1'b0; mlast <= 1'b1; mlock <= 1'b0; run <= 1;
      mrd[0] <= 32'h0; mrd[1] <= 32'h0;
    end else if (mph == 0) begin
      if (req != 2'b00) begin
        mph  <= 1;
        mown <= m_regr ? mlast : (req == 2'b11 ? !mlast : req[1]);
        run  <= m_regr ? run + 1 : 1;
      end
    end else if (mph == 1) begin
      mph <= 2;
      mlast <= mown;
      if (!wr[mown]) mrd[mown] <= rdw(addr[mown][7:0]);
    end else begin
      mph <= 0;
      mlock <= lk[mown];
      if (!(lk[mown] && req[!mown])) run <= 1;
    end
  end

  always @(negedge clk) begin
    chk("data_wr", 32'(d_wr), 32'((mph == 1) && wr[mown]));
    chk("data_addr", d_addr, mph == 1 ? addr[mown] : 32'h0);
    chk("data_in", d_in, mph == 1 ? wd[mown] : 32'h0);
    chk("m0_ack", 32'(ack0), 32'(mph == 2 && !mown));
    chk("m1_ack", 32'(ack1), 32'(mph == 2 && mown));
    chk("m0_rdata", rd0, mrd[0]);
    chk("m1_rdata", rd1, mrd[1]);
    chk("ack_excl", 32'(ack0 & ack1), 32'h0);
    if (ack0) glog.push_back(0);
    if (ack1) glog.push_back(1);
  end

  task automatic xfer(input int m, input logic w, input logic l, input logic [31:0] a,
                      input logic [31:0] d, input bit keep);
    bit got = 1'b0;
    wr[m] = w; lk[m] = l; addr[m] = a; wd[m] = d; req[m] = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      got = (m == 0) ? ack0 : ack1;
    end
    chk($sformatf("ack_m%0d", m), 32'(got), 32'h1);
    if (!keep) req[m] = 1'b0;
  endtask

  initial begin
    addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
    // reset release 3 ns after a falling edge
    @(negedge clk); @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 0); chk("rst_ack1", 32'(ack1), 0);
    chk("rst_dwr", 32'(d_wr), 0); chk("rst_daddr", d_addr, 0);
    chk("rst_rd0", rd0, 0); chk("rst_rd1", rd1, 0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); chk("idle_dwr", 32'(d_wr), 0); end
    // m0 writes 7 to 0x20
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h7; req[0] = 1'b1;
    @(negedge clk); chk("wr_t_dwr", 32'(d_wr), 0);
    @(negedge clk); chk("wr_t1_dwr", 32'(d_wr), 1); chk("wr_t1_ack", 32'(ack0), 0);
    chk("wr_t1_addr", d_addr, 32'h20);
    @(negedge clk); chk("wr_t2_dwr", 32'(d_wr), 0); chk("wr_t2_ack", 32'(ack0), 1);
    req[0] = 1'b0;
    @(negedge clk); chk("wr_t3_ack", 32'(ack0), 0);
    chk("mem20", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h0000_0007);
    // m1 reads it back
    @(posedge clk); #1;
    wr[1] = 1'b0; addr[1] = 32'h20; req[1] = 1'b1;
    @(negedge clk); @(negedge clk); chk("rd_t1_ack", 32'(ack1), 0);
    @(negedge clk); chk("rd_t2_ack", 32'(ack1), 1); chk("rd_m1_rdata", rd1, 32'h7);
    chk("rd_m0_rdata", rd0, 32'h0);
    req[1] = 1'b0;
    @(negedge clk);
    // contention, unlocked
    glog.delete();
    fork
      for (int k = 0; k < 4; k++) xfer(0, 1'b1, 1'b0, 32'h00, 32'hA0 + 32'(k), k < 3);
      for (int k = 0; k < 4; k++) xfer(1, 1'b1, 1'b0, 32'h04, 32'hB0 + 32'(k), k < 3);
    join
    repeat (3) @(negedge clk);
    chk("rr_count", 32'(glog.size()), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(i % 2));
    chk("mem00", rdw(8'h00), 32'hA3); chk("mem04", rdw(8'h04), 32'hB3);
    // lock bound with MAX_HOLD = 2
    glog.delete();
    fork
      for (int k = 0; k < 6; k++) xfer(0, 1'b0, 1'b1, 32'h00, 32'h0, k < 5);
      for (int k = 0; k < 2; k++) xfer(1, 1'b1, 1'b0, 32'h08, 32'hC0 + 32'(k), k < 1);
    join
    lk[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("lk_count", 32'(glog.size()), 8);
    begin
      int exp_lk [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8 && i < glog.size(); i++) chk($sformatf("lk_order%0d", i), 32'(glog[i]), 32'(exp_lk[i]));
    end
    chk("lk_rd0", rd0, 32'hA3);
    // reset in the middle of an m1 write
    @(posedge clk); #1;
    wr[1] = 1'b1; addr[1] = 32'h38; wd[1] = 32'hDEAD_BEEF; req[1] = 1'b1;
    @(posedge clk); #3;
    chk("mid_dwr_pre", 32'(d_wr), 1);
    rst_n = 1'b0;
    #1 chk("mid_dwr_post", 32'(d_wr), 0); chk("mid_ack1", 32'(ack1), 0);
    req[1] = 1'b0;
    @(negedge clk); @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk); chk("mid_ack1_after", 32'(ack1), 0);
    chk("mem38", rdw(8'h38), 32'h1122_3344);
    // a fresh request is served with normal latency, so the FSM restarted in IDLE
    @(posedge clk); #1;
    wr[0] = 1'b0; addr[0] = 32'h38; req[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); chk("post_ack0", 32'(ack0), 1); chk("post_rd0", rd0, 32'h1122_3344);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
